// File: rtl/module_arbitro_mux_4_1.sv
// Round-robin arbiter (with RAFAGA burst allowance) sharing one 4:1 mux among requesters a..d,
// with a registered valid/ready output stage. Define ARB_PRIORIDAD_FIJA_EN for fixed priority a>b>c>d.
module module_arbitro_mux_4_1 #(
  parameter int ANCHO  = 8,
  parameter int RAFAGA = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [ANCHO-1:0] c,
  input  logic [ANCHO-1:0] d,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [ANCHO-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {LIBRE, OCUPADO} estado_t;

  estado_t          estado;
  logic             can_load;
  logic [1:0]       ganador;
  logic [ANCHO-1:0] dato;

`ifdef ARB_PRIORIDAD_FIJA_EN
  // Lowest set request bit wins; scanning downward lets index 0 overwrite last.
  always_comb begin
    ganador = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) ganador = 2'(k);
    end
  end
`else
  localparam logic [3:0] LIMITE = 4'(RAFAGA - 1);

  logic [1:0] puntero;
  logic [3:0] cuenta;
  logic [1:0] idx;

  // First set request scanning upward from the pointer, wrapping 3->0.
  always_comb begin
    ganador = puntero;
    idx     = puntero;
    for (int k = 3; k >= 0; k--) begin
      idx = puntero + 2'(k);
      if (req[idx]) ganador = idx;
    end
  end

  // sel doubles as the previous winner; the pointer only moves on after a full burst
  // or once the bursting requester lets go of its request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puntero <= 2'd0;
      cuenta  <= 4'd0;
    end else if (|gnt) begin
      if (ganador == sel && cuenta < LIMITE) begin
        cuenta  <= cuenta + 4'd1;
        puntero <= ganador;
      end else if (ganador != sel && RAFAGA > 1) begin
        cuenta  <= 4'd1;
        puntero <= ganador;
      end else begin
        cuenta  <= 4'd0;
        puntero <= ganador + 2'd1;
      end
    end else if (cuenta != 4'd0 && !req[sel]) begin
      cuenta  <= 4'd0;
      puntero <= sel + 2'd1;
    end
  end
`endif

  always_comb begin
    case (ganador)
      2'd0:    dato = a;
      2'd1:    dato = b;
      2'd2:    dato = c;
      default: dato = d;
    endcase
  end

  assign can_load = (estado == LIBRE) || out_ready;
  assign gnt      = (rst_n && can_load && (|req)) ? (4'b0001 << ganador) : 4'b0000;

  // A grant always (re)loads the output; otherwise an accept empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= LIBRE;
      out       <= '0;
      sel       <= 2'd0;
      out_valid <= 1'b0;
    end else if (|gnt) begin
      estado    <= OCUPADO;
      out       <= dato;
      sel       <= ganador;
      out_valid <= 1'b1;
    end else if (estado == OCUPADO && out_ready) begin
      estado    <= LIBRE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_module_arbitro_mux_4_1.sv
// Bench for module_arbitro_mux_4_1: two instances (RAFAGA=1 and RAFAGA=3) checked every cycle
// against a grant-history model, plus directed literal checks.
module tb_module_arbitro_mux_4_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, c, d;
  logic [3:0] req;
  logic       out_ready;

  logic [3:0] gnt1, gnt3;
  logic [1:0] sel1, sel3;
  logic [7:0] out1, out3;
  logic       valid1, valid3;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  module_arbitro_mux_4_1 #(.ANCHO(8), .RAFAGA(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .req(req),
    .gnt(gnt1), .sel(sel1), .out(out1), .out_valid(valid1), .out_ready(out_ready));

  module_arbitro_mux_4_1 #(.ANCHO(8), .RAFAGA(3)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .req(req),
    .gnt(gnt3), .sel(sel3), .out(out3), .out_valid(valid3), .out_ready(out_ready));

  // Model state per instance: held word, validity, last winner, grants in the current burst, scan start.
  int   raf [2] = '{1, 3};
  int   mPtr [2];
  int   mRun [2];
  int   mLast [2];
  logic [7:0] mOut [2];
  logic [1:0] mSel [2];
  logic       mValid [2];

  function automatic logic [7:0] wordOf(input int w);
    case (w)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  function automatic int modelWinner(input int i);
    if (!rst_n || req == 4'b0000) return -1;
    if (mValid[i] && !out_ready) return -1;
`ifdef ARB_PRIORIDAD_FIJA_EN
    for (int k = 0; k < 4; k++) if (req[k]) return k;
`else
    for (int k = 0; k < 4; k++) if (req[(mPtr[i] + k) % 4]) return (mPtr[i] + k) % 4;
`endif
    return -1;
  endfunction

  function automatic logic [3:0] modelGnt(input int i);
    int w;
    w = modelWinner(i);
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mPtr[i] = 0; mRun[i] = 0; mLast[i] = 0;
        mOut[i] = 8'h00; mSel[i] = 2'd0; mValid[i] = 1'b0;
      end else begin
        int w;
        w = modelWinner(i);
        if (w >= 0) begin
          mOut[i] = wordOf(w);
          mSel[i] = 2'(w);
          mValid[i] = 1'b1;
          mRun[i] = (w == mLast[i]) ? mRun[i] + 1 : 1;
          if (mRun[i] >= raf[i]) begin
            mPtr[i] = (w + 1) % 4;
            mRun[i] = 0;
          end else begin
            mPtr[i] = w;
          end
          mLast[i] = w;
        end else begin
          if (mValid[i] && out_ready) mValid[i] = 1'b0;
          if (mRun[i] > 0 && !req[mLast[i]]) begin
            mPtr[i] = (mLast[i] + 1) % 4;
            mRun[i] = 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("m1.gnt",   32'(gnt1),   32'(modelGnt(0)));
    checkOutput("m1.out",   32'(out1),   32'(mOut[0]));
    checkOutput("m1.sel",   32'(sel1),   32'(mSel[0]));
    checkOutput("m1.valid", 32'(valid1), 32'(mValid[0]));
    checkOutput("m3.gnt",   32'(gnt3),   32'(modelGnt(1)));
    checkOutput("m3.out",   32'(out3),   32'(mOut[1]));
    checkOutput("m3.sel",   32'(sel3),   32'(mSel[1]));
    checkOutput("m3.valid", 32'(valid3), 32'(mValid[1]));
  end

  task automatic applyStimulus(input logic [3:0] reqV, input logic readyV);
    @(posedge clk);
    #2;
    req = reqV;
    out_ready = readyV;
  endtask

  task automatic doReset(input logic [3:0] reqV, input logic readyV);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = reqV;
    out_ready = readyV;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [7:0] rrOut [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [1:0] rrSel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] burstSel [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};

  initial begin
    rst_n = 1'b0;
    req = 4'hF;
    out_ready = 1'b1;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;

    // Reset with all requests high
    repeat (2) @(negedge clk);
    checkOutput("rst.gnt",   32'(gnt1),   32'h0);
    checkOutput("rst.out",   32'(out1),   32'h0);
    checkOutput("rst.valid", 32'(valid1), 32'h0);
    checkOutput("rst.sel",   32'(sel1),   32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel.gnt", 32'(gnt1), 32'h1);

    // Round-robin, RAFAGA=1
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rr.out",   32'(out1),   32'(rrOut[i]));
      checkOutput("rr.sel",   32'(sel1),   32'(rrSel[i]));
      checkOutput("rr.valid", 32'(valid1), 32'h1);
    end

    // Backpressure holding 22
    applyStimulus(4'hF, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp.out", 32'(out1), 32'h22);
      checkOutput("bp.sel", 32'(sel1), 32'h1);
      checkOutput("bp.gnt", 32'(gnt1), 32'h0);
    end
    applyStimulus(4'hF, 1'b1);
    @(negedge clk);
    checkOutput("bp.regnt", 32'(gnt1), 32'h4);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp.reload", 32'(out1), 32'h33);

    // Burst of three on the RAFAGA=3 instance
    doReset(4'b0101, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("burst.sel", 32'(sel3), 32'(burstSel[i]));
      checkOutput("burst.out", 32'(out3), (burstSel[i] == 2'd0) ? 32'h11 : 32'h33);
    end

    // Abandoned burst: a drops after its second grant
    doReset(4'b0101, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 req = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abandon.sel", 32'(sel3), 32'h2);
    checkOutput("abandon.out", 32'(out3), 32'h33);

    // Single requester d with pulsed acceptance
    d = 8'hA5;
    doReset(4'b1000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single.out",   32'(out1),   32'hA5);
    checkOutput("single.valid", 32'(valid1), 32'h1);
    repeat (2) begin
      applyStimulus(4'b1000, 1'b1);
      @(negedge clk);
      checkOutput("single.gnt", 32'(gnt1), 32'h8);
      applyStimulus(4'b1000, 1'b0);
      @(negedge clk);
      checkOutput("single.hold", 32'(out1), 32'hA5);
      checkOutput("single.gnt0", 32'(gnt1), 32'h0);
    end
    applyStimulus(4'b0000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain.valid", 32'(valid1), 32'h0);
    checkOutput("drain.out",   32'(out1),   32'hA5);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle.valid", 32'(valid1), 32'h0);

    // Asynchronous reset between edges while holding 33
    doReset(4'b0100, 1'b1);
    @(posedge clk);
    #2;
    req = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("pre.out", 32'(out1), 32'h33);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req = 4'b0100;
    #1;
    checkOutput("arst.out",   32'(out1),   32'h0);
    checkOutput("arst.valid", 32'(valid1), 32'h0);
    checkOutput("arst.gnt",   32'(gnt1),   32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

`ifdef ARB_PRIORIDAD_FIJA_EN
    doReset(4'hE, 1'b1);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("fixed.sel", 32'(sel1), 32'h1);
      checkOutput("fixed.out", 32'(out1), 32'h22);
    end
`else
    doReset(4'hE, 1'b1);
    repeat (6) @(posedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
